aes128_req_sched: RTL
=====================

Name: aes128_req_sched

Overview:
Sequencer and arbiter that shares one combinational AES-128 encryption core (`main`: data, key128 -> out128) between NUM_REQ requesters. It accepts one request at a time using round-robin arbitration and registers the plaintext and key onto the core inputs. It holds those inputs stable for a fixed multicycle settle window, then captures out128 and returns it with the requester ID over a valid/ready response channel. It sits between the requester ports and the core.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
SETTLE_CYCLES, 4, cycles core inputs are held before out128 is sampled (>=1; matches the multicycle constraint on the core)
ID_W, 1, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_data  in  NUM_REQ*128  plaintext; requester i uses bits [128*i +: 128]
req_key128  in  NUM_REQ*128  key; requester i uses bits [128*i +: 128]
core_data  out  128  registered plaintext to core .data
core_key128  out  128  registered key to core .key128
core_out128  in  128  ciphertext from core .out128
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_out128  out  128  captured ciphertext
rsp_id  out  ID_W  index of the requester that owns the response
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rr_ptr=0, settle counter=0; all outputs are 0 (req_ready, core_data, core_key128, rsp_valid, rsp_out128, rsp_id, busy).
- Reset mid-operation drops any in-flight request and response. A requester whose req_valid is still high is re-arbitrated after reset.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally, only in IDLE; all other bits are 0. No valid input means req_ready=0.
  - On handshake at edge T: core_data and core_key128 load the granted slices; gnt_id=grant; counter=SETTLE_CYCLES-1; rr_ptr=(grant+1) mod NUM_REQ; state goes to SETTLE.
- SETTLE:
  - Core inputs are held constant. The counter decrements each cycle.
  - At the edge where counter==0: rsp_out128 captures core_out128, rsp_id=gnt_id, rsp_valid=1, state goes to RESP.
  - Latency: the request handshake at edge T gives rsp_valid=1 after edge T+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_out128 and rsp_id hold until rsp_ready=1 at an edge. At that edge rsp_valid goes to 0 and state goes to IDLE.
  - No bypass: a new request can be accepted one cycle after the response handshake at the earliest.
  - core_data and core_key128 keep their last values after RESP; they are not cleared.
- Throughput: one request per SETTLE_CYCLES+2 cycles when rsp_ready is tied high.
- Simultaneous valids: only one is granted per IDLE cycle. Round-robin guarantees each valid requester is served within NUM_REQ grants.
- Requester rules:
  - Once asserted, req_valid must stay high, with stable req_data and req_key128, until req_ready. The bench checks this; the RTL does not depend on it.
  - Payload changes while waiting are sampled only at the handshake edge.
- rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Package aes128_pkg: AES_BLK_W=128, AES_KEY_W=128, and the state enum (IDLE/SETTLE/RESP).
- One natural sub-module, aes128_rr_arb (NUM_REQ): inputs req_valid and rr_ptr; outputs grant index and any_valid. It is purely combinational and reusable.
- The AES core `main` is instantiated by the integrating top, not inside this block.

Test Plan:
- Single request, SP 800-38A vector: requester 0 sends data=6bc1bee22e409f96e93d7e117393172a, key128=2b7e151628aed2a6abf7158809cf4f3c, rsp_ready=1 -> rsp_valid rises exactly SETTLE_CYCLES edges after the handshake; rsp_out128=3ad77bb40d7a3660a89ecaf32466ef97; rsp_id=0.
- Contention: both requesters valid from reset, requester 1 using FIPS-197 C.1 (data=00112233445566778899aabbccddeeff, key128=000102030405060708090a0b0c0d0e0f) -> grant order is 0, then 1. Responses come in that order: rsp_id=1 carries 69c4e0d86e7b0432d8cdb78070b4c55a. req_ready is never multi-hot.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_out128 and rsp_id are stable. req_ready stays 0 while requester 1 is valid. Requester 1 is granted the cycle after rsp_ready=1.
- Fairness: requesters 0 and 1 continuously valid for 6 transactions -> rsp_id sequence is 0,1,0,1,0,1.
- Reset mid-SETTLE: drop rst_n for 1 cycle during SETTLE -> all outputs are 0 next cycle, no rsp_valid for the dropped request, rr_ptr=0. Requester 0, still valid, is re-granted.
- SETTLE_CYCLES=1 build: run the single-request vector again -> rsp_valid after 1 edge, same ciphertext.

Source files
------------

// File: rtl/aes128_pkg.sv
// aes128_pkg: shared widths and FSM state encoding for the AES-128 request scheduler
package aes128_pkg;
   localparam int AES_BLK_W = 128;
   localparam int AES_KEY_W = 128;
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;
endpackage

// File: rtl/aes128_rr_arb.sv
// aes128_rr_arb: combinational round-robin pick of the first valid requester at or after rr_ptr
module aes128_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int ID_W = 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    grant,
   output logic               any_valid
);
   int j;
   always_comb begin
      grant = '0;
      any_valid = 1'b0;
      j = 0;
      // descending scan so the smallest offset from rr_ptr is assigned last and wins
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[j]) begin
            grant = ID_W'(j);
            any_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/aes128_req_sched.sv
// aes128_req_sched: round-robin sequencer sharing one combinational AES-128 core,
// holding core inputs for a multicycle settle window before capturing the ciphertext
module aes128_req_sched
   import aes128_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int ID_W = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
   input  logic [NUM_REQ*AES_KEY_W-1:0] req_key128,
   output logic [AES_BLK_W-1:0]         core_data,
   output logic [AES_KEY_W-1:0]         core_key128,
   input  logic [AES_BLK_W-1:0]         core_out128,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [AES_BLK_W-1:0]         rsp_out128,
   output logic [ID_W-1:0]              rsp_id,
   output logic                         busy
);
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   state_e               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, rsp_id_q, rsp_id_d, grant;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [AES_BLK_W-1:0] data_q, data_d, out_q, out_d;
   logic [AES_KEY_W-1:0] key_q, key_d;
   logic                 rv_q, rv_d, any_valid, accept;
   aes128_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req_valid(req_valid),
      .rr_ptr(rr_ptr_q),
      .grant(grant),
      .any_valid(any_valid)
   );
   // ready is masked during reset so no requester sees a handshake that reset discards
   assign accept = (state_q == IDLE) && any_valid && rst_n;
   assign req_ready = NUM_REQ'(accept) << grant;
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d = gnt_q;
      cnt_d = cnt_q;
      data_d = data_q;
      key_d = key_q;
      rv_d = rv_q;
      out_d = out_q;
      rsp_id_d = rsp_id_q;
      case (state_q)
         IDLE: if (accept) begin
            data_d = req_data[AES_BLK_W*int'(grant) +: AES_BLK_W];
            key_d = req_key128[AES_KEY_W*int'(grant) +: AES_KEY_W];
            gnt_d = grant;
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
            rr_ptr_d = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            state_d = SETTLE;
         end
         SETTLE: if (cnt_q == '0) begin
            out_d = core_out128;
            rsp_id_d = gnt_q;
            rv_d = 1'b1;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         RESP: if (rsp_ready) begin
            rv_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_ptr_q <= '0;
         gnt_q <= '0;
         cnt_q <= '0;
         data_q <= '0;
         key_q <= '0;
         rv_q <= 1'b0;
         out_q <= '0;
         rsp_id_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q <= gnt_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         key_q <= key_d;
         rv_q <= rv_d;
         out_q <= out_d;
         rsp_id_q <= rsp_id_d;
      end
   end
   assign core_data = data_q;
   assign core_key128 = key_q;
   assign rsp_valid = rv_q;
   assign rsp_out128 = out_q;
   assign rsp_id = rsp_id_q;
   assign busy = state_q != IDLE;
endmodule
